// File: rtl/fp_sum_arbiter_if.sv
// Bus bundle between two requesters, the shared FP adder and fp_sum_arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface fp_sum_arbiter_if;
    logic        req0_vld_i;
    logic        req0_rdy_o;
    logic [31:0] req0_a_i;
    logic [31:0] req0_b_i;
    logic        req1_vld_i;
    logic        req1_rdy_o;
    logic [31:0] req1_a_i;
    logic [31:0] req1_b_i;
    logic        res0_vld_o;
    logic [31:0] res0_o;
    logic [1:0]  res0_status_o;
    logic        res1_vld_o;
    logic [31:0] res1_o;
    logic [1:0]  res1_status_o;
    logic        fpu_vld_o;
    logic [31:0] fpu_a_o;
    logic [31:0] fpu_b_o;
    logic [31:0] fpu_answer_i;
    logic [1:0]  fpu_status_i;
    logic        busy_o;

    modport slave (
        input  req0_vld_i, req0_a_i, req0_b_i,
        input  req1_vld_i, req1_a_i, req1_b_i,
        input  fpu_answer_i, fpu_status_i,
        output req0_rdy_o, req1_rdy_o,
        output res0_vld_o, res0_o, res0_status_o,
        output res1_vld_o, res1_o, res1_status_o,
        output fpu_vld_o, fpu_a_o, fpu_b_o, busy_o
    );

    modport master (
        output req0_vld_i, req0_a_i, req0_b_i,
        output req1_vld_i, req1_a_i, req1_b_i,
        output fpu_answer_i, fpu_status_i,
        input  req0_rdy_o, req1_rdy_o,
        input  res0_vld_o, res0_o, res0_status_o,
        input  res1_vld_o, res1_o, res1_status_o,
        input  fpu_vld_o, fpu_a_o, fpu_b_o, busy_o
    );
endinterface

// File: rtl/fp_sum_arbiter.sv
// Round-robin sharing of one pipelined FP adder between two requesters; an owner
// tag pipeline matched to the adder latency steers each result back to its issuer.
module fp_sum_arbiter #(
    parameter int unsigned LATENCY = 32'd3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    fp_sum_arbiter_if.slave    bus
);

    logic               ptr_q, ptr_d;
    logic               rdy0_s, rdy1_s;
    logic               grant0_s, grant1_s;
    logic               fpu_vld_q, fpu_vld_d;
    logic               fpu_own_q, fpu_own_d;
    logic [31:0]        fpu_a_q, fpu_a_d;
    logic [31:0]        fpu_b_q, fpu_b_d;
    logic [LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [LATENCY-1:0] tag_own_q, tag_own_d;
    logic [LATENCY:0]   tag_vld_ext_s, tag_own_ext_s;
    logic               ret_vld_s, ret_own_s;
    logic               res0_vld_q, res0_vld_d;
    logic [31:0]        res0_q, res0_d;
    logic [1:0]         res0_status_q, res0_status_d;
    logic               res1_vld_q, res1_vld_d;
    logic [31:0]        res1_q, res1_d;
    logic [1:0]         res1_status_q, res1_status_d;
    logic               busy_q, busy_d;

    // Ready is withheld only from the requester that lacks priority while the other is valid.
    always_comb begin
        rdy0_s   = !(bus.req1_vld_i && (ptr_q == 1'b1));
        rdy1_s   = !(bus.req0_vld_i && (ptr_q == 1'b0));
        grant0_s = bus.req0_vld_i && rdy0_s;
        grant1_s = bus.req1_vld_i && rdy1_s && !grant0_s;
    end

    // Next state: issue register, owner tag shift, result steering and busy.
    always_comb begin
        ptr_d     = ptr_q;
        fpu_vld_d = grant0_s || grant1_s;
        fpu_own_d = fpu_own_q;
        fpu_a_d   = fpu_a_q;
        fpu_b_d   = fpu_b_q;
        if (grant0_s) begin
            ptr_d     = 1'b1;
            fpu_own_d = 1'b0;
            fpu_a_d   = bus.req0_a_i;
            fpu_b_d   = bus.req0_b_i;
        end else if (grant1_s) begin
            ptr_d     = 1'b0;
            fpu_own_d = 1'b1;
            fpu_a_d   = bus.req1_a_i;
            fpu_b_d   = bus.req1_b_i;
        end else begin
            ptr_d     = ptr_q;
        end

        // Stage 0 captures the op as the adder samples it, so the last stage lines up with fpu_answer_i.
        tag_vld_ext_s = {tag_vld_q, fpu_vld_q};
        tag_own_ext_s = {tag_own_q, fpu_own_q};
        tag_vld_d     = tag_vld_ext_s[LATENCY-1:0];
        tag_own_d     = tag_own_ext_s[LATENCY-1:0];
        ret_vld_s     = tag_vld_q[LATENCY-1];
        ret_own_s     = tag_own_q[LATENCY-1];

        res0_vld_d    = 1'b0;
        res0_d        = res0_q;
        res0_status_d = res0_status_q;
        res1_vld_d    = 1'b0;
        res1_d        = res1_q;
        res1_status_d = res1_status_q;
        if (ret_vld_s && (ret_own_s == 1'b0)) begin
            res0_vld_d    = 1'b1;
            res0_d        = bus.fpu_answer_i;
            res0_status_d = bus.fpu_status_i;
        end else if (ret_vld_s && (ret_own_s == 1'b1)) begin
            res1_vld_d    = 1'b1;
            res1_d        = bus.fpu_answer_i;
            res1_status_d = bus.fpu_status_i;
        end else begin
            res0_vld_d    = 1'b0;
            res1_vld_d    = 1'b0;
        end

        busy_d = fpu_vld_d || (|tag_vld_d) || res0_vld_d || res1_vld_d;
    end

    // State registers; reset discards every in-flight tag so flushed ops never report.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q         <= 1'b0;
            fpu_vld_q     <= 1'b0;
            fpu_own_q     <= 1'b0;
            fpu_a_q       <= 32'd0;
            fpu_b_q       <= 32'd0;
            tag_vld_q     <= '0;
            tag_own_q     <= '0;
            res0_vld_q    <= 1'b0;
            res0_q        <= 32'd0;
            res0_status_q <= 2'd0;
            res1_vld_q    <= 1'b0;
            res1_q        <= 32'd0;
            res1_status_q <= 2'd0;
            busy_q        <= 1'b0;
        end else begin
            ptr_q         <= ptr_d;
            fpu_vld_q     <= fpu_vld_d;
            fpu_own_q     <= fpu_own_d;
            fpu_a_q       <= fpu_a_d;
            fpu_b_q       <= fpu_b_d;
            tag_vld_q     <= tag_vld_d;
            tag_own_q     <= tag_own_d;
            res0_vld_q    <= res0_vld_d;
            res0_q        <= res0_d;
            res0_status_q <= res0_status_d;
            res1_vld_q    <= res1_vld_d;
            res1_q        <= res1_d;
            res1_status_q <= res1_status_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.req0_rdy_o    = rdy0_s;
    assign bus.req1_rdy_o    = rdy1_s;
    assign bus.fpu_vld_o     = fpu_vld_q;
    assign bus.fpu_a_o       = fpu_a_q;
    assign bus.fpu_b_o       = fpu_b_q;
    assign bus.res0_vld_o    = res0_vld_q;
    assign bus.res0_o        = res0_q;
    assign bus.res0_status_o = res0_status_q;
    assign bus.res1_vld_o    = res1_vld_q;
    assign bus.res1_o        = res1_q;
    assign bus.res1_status_o = res1_status_q;
    assign bus.busy_o        = busy_q;

endmodule

// File: tb/tb_fp_sum_arbiter.sv
// Directed bench for fp_sum_arbiter with a stub adder of LATENCY register stages
// that knows the two test sums and otherwise returns a ^ b.
module tb_fp_sum_arbiter;
    localparam int LAT = 3;

    typedef struct packed {
        int unsigned cyc;
        logic [31:0] data;
        logic [1:0]  st;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int          tests = 0;
    int          fails = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    logic [33:0] add_pipe [LAT];

    fp_sum_arbiter_if bus();

    fp_sum_arbiter #(.LATENCY(LAT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [33:0] stub_add(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F60_0000 && b == 32'h400C_CCCD) return {2'b01, 32'h4044_CCCD};
        else if (a == 32'h3F80_0000 && b == 32'h3F80_0000) return {2'b01, 32'h4000_0000};
        else return {2'b10, a ^ b};
    endfunction

    // Stub adder: never reset, keeps producing data regardless of the arbiter.
    always @(posedge clk) begin
        add_pipe[0] <= stub_add(bus.fpu_a_o, bus.fpu_b_o);
        for (int i = 1; i < LAT; i++) add_pipe[i] <= add_pipe[i-1];
    end
    assign bus.fpu_answer_i = add_pipe[LAT-1][31:0];
    assign bus.fpu_status_i = add_pipe[LAT-1][33:32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_results();
        logic e0, e1;
        e0 = (q0.size() > 0) && (q0[0].cyc == cyc);
        e1 = (q1.size() > 0) && (q1[0].cyc == cyc);
        chk("res0_vld", 32'(bus.res0_vld_o), 32'(e0));
        chk("res1_vld", 32'(bus.res1_vld_o), 32'(e1));
        if (e0) begin
            chk("res0_data", bus.res0_o, q0[0].data);
            chk("res0_status", 32'(bus.res0_status_o), 32'(q0[0].st));
            void'(q0.pop_front());
        end
        if (e1) begin
            chk("res1_data", bus.res1_o, q1[0].data);
            chk("res1_status", 32'(bus.res1_status_o), 32'(q1[0].st));
            void'(q1.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        check_results();
    endtask

    // Called just before the tick whose edge should carry the handshake.
    task automatic expect_res(input logic own, input logic [31:0] d, input logic [1:0] st);
        exp_t e;
        e.cyc  = cyc + LAT + 2;
        e.data = d;
        e.st   = st;
        if (own) q1.push_back(e);
        else     q0.push_back(e);
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && (q0.size() > 0 || q1.size() > 0); k++) tick();
        chk("drain_pending", 32'(q0.size() + q1.size()), 32'd0);
        tick();
        chk("drain_busy", 32'(bus.busy_o), 32'd0);
    endtask

    initial begin
        bus.req0_vld_i = 1'b0; bus.req0_a_i = 32'd0; bus.req0_b_i = 32'd0;
        bus.req1_vld_i = 1'b0; bus.req1_a_i = 32'd0; bus.req1_b_i = 32'd0;

        // Reset state
        tick(); tick();
        chk("rst_fpu_vld", 32'(bus.fpu_vld_o), 32'd0);
        chk("rst_fpu_a", bus.fpu_a_o, 32'd0);
        chk("rst_fpu_b", bus.fpu_b_o, 32'd0);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_res0", bus.res0_o, 32'd0);
        chk("rst_res1", bus.res1_o, 32'd0);
        chk("rst_res0_st", 32'(bus.res0_status_o), 32'd0);
        rst = 1'b0;

        // Single request on req0
        bus.req0_vld_i = 1'b1; bus.req0_a_i = 32'h3F60_0000; bus.req0_b_i = 32'h400C_CCCD;
        #1;
        chk("t1_rdy0", 32'(bus.req0_rdy_o), 32'd1);
        chk("t1_rdy1", 32'(bus.req1_rdy_o), 32'd0);
        expect_res(1'b0, 32'h4044_CCCD, 2'b01);
        tick();
        bus.req0_vld_i = 1'b0;
        chk("t1_fpu_vld", 32'(bus.fpu_vld_o), 32'd1);
        chk("t1_fpu_a", bus.fpu_a_o, 32'h3F60_0000);
        chk("t1_fpu_b", bus.fpu_b_o, 32'h400C_CCCD);
        chk("t1_busy", 32'(bus.busy_o), 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t1_busy_mid", 32'(bus.busy_o), 32'd1);
            chk("t1_fpu_idle", 32'(bus.fpu_vld_o), 32'd0);
            chk("t1_fpu_a_hold", bus.fpu_a_o, 32'h3F60_0000);
        end
        tick();
        chk("t1_busy_end", 32'(bus.busy_o), 32'd0);
        chk("t1_res0_hold", bus.res0_o, 32'h4044_CCCD);

        // Back-to-back req1, req0 idle
        for (int i = 0; i < 5; i++) begin
            bus.req1_vld_i = 1'b1;
            bus.req1_a_i   = 32'h1000_0000 + 32'(i);
            bus.req1_b_i   = 32'h0000_00F0;
            #1;
            chk("b2b_rdy1", 32'(bus.req1_rdy_o), 32'd1);
            expect_res(1'b1, (32'h1000_0000 + 32'(i)) ^ 32'h0000_00F0, 2'b10);
            tick();
            chk("b2b_fpu_vld", 32'(bus.fpu_vld_o), 32'd1);
            chk("b2b_fpu_a", bus.fpu_a_o, 32'h1000_0000 + 32'(i));
        end
        bus.req1_vld_i = 1'b0;
        drain();

        // Contention: grants alternate starting with req0; req1 operands held while stalled
        bus.req0_vld_i = 1'b1; bus.req0_a_i = 32'h3F80_0000; bus.req0_b_i = 32'h3F80_0000;
        bus.req1_vld_i = 1'b1; bus.req1_a_i = 32'h3F60_0000; bus.req1_b_i = 32'h400C_CCCD;
        for (int k = 0; k < 6; k++) begin
            #1;
            if ((k % 2) == 0) begin
                chk("cont_rdy0_win", 32'(bus.req0_rdy_o), 32'd1);
                chk("cont_rdy1_stall", 32'(bus.req1_rdy_o), 32'd0);
                expect_res(1'b0, 32'h4000_0000, 2'b01);
            end else begin
                chk("cont_rdy0_stall", 32'(bus.req0_rdy_o), 32'd0);
                chk("cont_rdy1_win", 32'(bus.req1_rdy_o), 32'd1);
                expect_res(1'b1, 32'h4044_CCCD, 2'b01);
            end
            tick();
            chk("cont_fpu_vld", 32'(bus.fpu_vld_o), 32'd1);
            chk("cont_fpu_a", bus.fpu_a_o, ((k % 2) == 0) ? 32'h3F80_0000 : 32'h3F60_0000);
            chk("cont_fpu_b", bus.fpu_b_o, ((k % 2) == 0) ? 32'h3F80_0000 : 32'h400C_CCCD);
        end
        bus.req0_vld_i = 1'b0; bus.req1_vld_i = 1'b0;
        drain();

        // Fairness after idle: ptr stays on req1 across idle cycles
        bus.req0_vld_i = 1'b1;
        #1;
        chk("fair_rdy0", 32'(bus.req0_rdy_o), 32'd1);
        expect_res(1'b0, 32'h4000_0000, 2'b01);
        tick();
        bus.req0_vld_i = 1'b0;
        tick(); tick();
        chk("fair_idle", 32'(bus.fpu_vld_o), 32'd0);
        bus.req0_vld_i = 1'b1;
        bus.req1_vld_i = 1'b1; bus.req1_a_i = 32'h1111_1111; bus.req1_b_i = 32'h2222_2222;
        #1;
        chk("fair_rdy0_low", 32'(bus.req0_rdy_o), 32'd0);
        chk("fair_rdy1_high", 32'(bus.req1_rdy_o), 32'd1);
        expect_res(1'b1, 32'h3333_3333, 2'b10);
        tick();
        chk("fair_first_a", bus.fpu_a_o, 32'h1111_1111);
        bus.req1_vld_i = 1'b0;
        #1;
        chk("fair_rdy0_next", 32'(bus.req0_rdy_o), 32'd1);
        expect_res(1'b0, 32'h4000_0000, 2'b01);
        tick();
        chk("fair_second_a", bus.fpu_a_o, 32'h3F80_0000);
        bus.req0_vld_i = 1'b0;
        drain();

        // Reset two cycles after issue flushes the op
        bus.req0_vld_i = 1'b1; bus.req0_a_i = 32'h3F60_0000; bus.req0_b_i = 32'h400C_CCCD;
        expect_res(1'b0, 32'h4044_CCCD, 2'b01);
        tick();
        bus.req0_vld_i = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        q0.delete();
        q1.delete();
        chk("mid_rst_fpu_vld", 32'(bus.fpu_vld_o), 32'd0);
        chk("mid_rst_fpu_a", bus.fpu_a_o, 32'd0);
        chk("mid_rst_busy", 32'(bus.busy_o), 32'd0);
        chk("mid_rst_res0", bus.res0_o, 32'd0);
        chk("mid_rst_res0_st", 32'(bus.res0_status_o), 32'd0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        bus.req0_vld_i = 1'b1; bus.req0_a_i = 32'h3F80_0000; bus.req0_b_i = 32'h3F80_0000;
        bus.req1_vld_i = 1'b1;
        #1;
        chk("post_rst_rdy0", 32'(bus.req0_rdy_o), 32'd1);
        chk("post_rst_rdy1", 32'(bus.req1_rdy_o), 32'd0);
        expect_res(1'b0, 32'h4000_0000, 2'b01);
        tick();
        bus.req0_vld_i = 1'b0;
        expect_res(1'b1, 32'h3333_3333, 2'b10);
        tick();
        bus.req1_vld_i = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fp_sum_arbiter.md
Name: fp_sum_arbiter

Overview:
- Shares one `pipelined_fp_summator` between two independent requesters.
- Arbitrates with round-robin priority and issues at most one operand pair per cycle into the adder.
- Tracks the owner of every in-flight operation in a tag pipeline that matches the adder latency.
- Routes each sum and its 2-bit number status back to the requester that issued it.

Parameters:
- LATENCY, 3: cycles from `fpu_vld_o` high at a clock edge to the matching result on `fpu_answer_i`/`fpu_status_i`; legal range 1..16.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- req0_vld_i  input  1  requester 0 operand pair valid.
- req0_rdy_o  output  1  requester 0 accepted this cycle.
- req0_a_i  input  32  requester 0 operand A, IEEE-754 single.
- req0_b_i  input  32  requester 0 operand B.
- req1_vld_i, req1_rdy_o, req1_a_i, req1_b_i: same as requester 0, for requester 1.
- res0_vld_o  output  1  one-cycle pulse, result for requester 0.
- res0_o  output  32  sum for requester 0.
- res0_status_o  output  2  number status for requester 0.
- res1_vld_o, res1_o, res1_status_o: same as requester 0, for requester 1.
- fpu_vld_o  output  1  to adder `vld_i`.
- fpu_a_o  output  32  to adder `a_i`.
- fpu_b_o  output  32  to adder `b_i`.
- fpu_answer_i  input  32  from adder `answer_o`.
- fpu_status_i  input  2  from adder `num_status_o`.
- busy_o  output  1  any operation issued and not yet returned.

Behaviour:
- Clock and reset: single clock `clk_i`; `rst_i` asynchronous, active-high.
- Reset values:
  - All `*_vld_o`, `res*_o`, `res*_status_o`, `fpu_a_o`, `fpu_b_o`, `busy_o` = 0.
  - Tag pipeline cleared; priority pointer `ptr` = 0.
- Ready (combinational, from current inputs and `ptr`):
  - `req0_rdy_o = !(req1_vld_i && ptr==1)`.
  - `req1_rdy_o = !(req0_vld_i && ptr==0)`.
  - Ready may be high with valid low; no transfer occurs then.
- Handshake and grant:
  - Transfer happens on `vld && rdy` at a rising edge; at most one grant per cycle.
  - A requester held off by `rdy` low keeps its `vld` and operands stable.
- Pointer update:
  - After a grant to requester k, `ptr <= ~k`.
  - With no grant, `ptr` holds.
  - Under sustained contention the grants strictly alternate.
- Issue stage (registered):
  - The cycle after a grant: `fpu_vld_o` = 1, `fpu_a_o`/`fpu_b_o` = granted operands.
  - With no grant: `fpu_vld_o` = 0 and `fpu_a_o`/`fpu_b_o` hold their last value.
  - Throughput is 1 operation per cycle; the adder never stalls, so this block never back-pressures on results.
- Tag pipeline:
  - LATENCY-deep shift register of {valid, owner}, loaded alongside `fpu_vld_o`.
  - Tag stage LATENCY is aligned with `fpu_answer_i`.
- Return stage (registered):
  - When the emerging tag is valid, register `fpu_answer_i`/`fpu_status_i` into `res<owner>_o`/`res<owner>_status_o`.
  - Pulse `res<owner>_vld_o` for exactly 1 cycle.
  - The other requester's `res*_vld_o` stays 0.
  - `res*_o` holds its value between pulses.
- Latency: request handshake edge N -> `res_vld_o` high in cycle N + LATENCY + 2.
- Ordering: results per requester return in issue order; `res0_vld_o` and `res1_vld_o` are never high in the same cycle.
- `busy_o` (registered) = `fpu_vld_o` OR any tag valid OR return valid in flight; 0 only when fully drained.
- Datapath is pass-through: no arithmetic or status modification; status encoding is owned by the adder.
- Reset mid-operation:
  - All in-flight tags are discarded; no `res_vld_o` pulse is produced for them, even though the adder may still output data.
  - `ptr` returns to 0.

Test Plan:
- Single request, LATENCY=3: `req0` = {0x3F600000, 0x400CCCCD} (0.875 + 2.2) at edge N -> `fpu_vld_o` at N+1; `res0_vld_o` 1-cycle pulse at N+5 with `res0_o` = 0x4044CCCD (3.075); `res1_vld_o` stays 0; `busy_o` 1 from N+1 to N+5, then 0.
- Contention: both `vld` held 6 cycles; `req0` = 1.0+1.0 (0x3F800000 pair), `req1` = 0.875+2.2 -> grants alternate 0,1,0,1,0,1 starting with `req0`; `res0_o` = 0x40000000 and `res1_o` = 0x4044CCCD, each pulsing every other cycle.
- Back-to-back single requester: `req1` valid for 5 consecutive cycles, `req0` idle -> `req1_rdy_o` high throughout; 5 consecutive `res1_vld_o` pulses in issue order; no bubbles.
- Fairness after idle: grant to `req0`, 2 idle cycles, then both valid -> `req1` wins first (`ptr` = 1 held across idle).
- Reset mid-flight: assert `rst_i` asynchronously 2 cycles after issue, release 1 cycle later -> outputs 0 immediately; no `res_vld_o` pulse for the flushed operation; a new request afterwards completes with correct latency.
- Stall stability: `req1` valid while losing to `req0` -> `req1_rdy_o` low that cycle; `req1` operands held are issued next cycle unchanged; result correct.
